// File: rtl/norm1_pkg.sv
`default_nettype none
// ============================================================================
// Module  : norm1_pkg
// Brief   : Shared widths, FSM states and saturation value for the norm1 divider
// Revision: 1.0
// ============================================================================
package norm1_pkg;

    localparam int N1_SUM_W  = 36;
    localparam int N1_NORM_W = 18;
    localparam int N1_CNT_W  = $clog2(N1_NORM_W);

    localparam logic [N1_NORM_W-1:0] Q_SAT = 18'h3FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : norm1_pkg
`default_nettype wire

// File: rtl/norm1_udiv_36ns_18ns_18_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : norm1_udiv_36ns_18ns_18_seq_if
// Brief   : ap_start/ap_done block handshake plus operand/result bus
// Revision: 1.0
// ============================================================================
interface norm1_udiv_36ns_18ns_18_seq_if
    import norm1_pkg::*;
#(
    parameter int din0_WIDTH = N1_SUM_W,
    parameter int din1_WIDTH = N1_NORM_W,
    parameter int dout_WIDTH = N1_NORM_W
);
    logic                  ap_start;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  ap_ready;
    logic                  ap_idle;
    logic                  ap_done;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;
    logic                  ovf;

    modport master (
        output ap_start, din0, din1,
        input  ap_ready, ap_idle, ap_done, dout, rem, ovf
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_ready, ap_idle, ap_done, dout, rem, ovf
    );

endinterface : norm1_udiv_36ns_18ns_18_seq_if
`default_nettype wire

// File: rtl/norm1_udiv_step.sv
`default_nettype none
// ============================================================================
// Module  : norm1_udiv_step
// Brief   : One combinational restoring-division step (one quotient bit)
// Revision: 1.0
// ============================================================================
module norm1_udiv_step
    import norm1_pkg::*;
#(
    parameter int W = N1_NORM_W
) (
    input  wire logic [W-1:0] r,
    input  wire logic [W-1:0] d,
    input  wire logic         bit_in,
    output logic      [W-1:0] r_out,
    output logic              q_bit
);

    logic [W:0] shifted;

    // The stored remainder stays below d, so only the shifted value needs W+1 bits
    // and the difference always fits back into W bits.
    always_comb begin
        shifted = {r, bit_in};
        q_bit   = (shifted >= {1'b0, d});
        r_out   = shifted[W-1:0] - (q_bit ? d : '0);
    end

endmodule : norm1_udiv_step
`default_nettype wire

// File: rtl/norm1_udiv_36ns_18ns_18_seq.sv
`default_nettype none
// ============================================================================
// Module  : norm1_udiv_36ns_18ns_18_seq
// Brief   : Sequential 36/18 unsigned restoring divider, one quotient bit per cycle
// Revision: 1.0
// ============================================================================
module norm1_udiv_36ns_18ns_18_seq
    import norm1_pkg::*;
#(
    parameter int din0_WIDTH = N1_SUM_W,
    parameter int din1_WIDTH = N1_NORM_W,
    parameter int dout_WIDTH = N1_NORM_W
) (
    input  wire logic                     ap_clk,
    input  wire logic                     ap_rst_n,
    norm1_udiv_36ns_18ns_18_seq_if.slave  bus
);

    localparam logic [N1_CNT_W-1:0] LAST_STEP = N1_CNT_W'(dout_WIDTH - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [din1_WIDTH-1:0]   div_q;
    logic [din1_WIDTH-1:0]   r_q;
    logic [dout_WIDTH-1:0]   q_q;
    logic [N1_CNT_W-1:0]     k_q;
    logic [dout_WIDTH-1:0]   dout_q;
    logic [din1_WIDTH-1:0]   rem_q;
    logic                    ovf_q;

    logic                    is_idle;
    logic                    accept;
    logic                    ovf_n;
    logic                    last_step;
    logic [din1_WIDTH-1:0]   step_r;
    logic                    step_bit;

    assign is_idle   = (state_q == IDLE) || (state_q == DONE);
    assign accept    = bus.ap_start && is_idle && ap_rst_n;
    assign ovf_n     = (bus.din0[din0_WIDTH-1:dout_WIDTH] >= bus.din1);
    assign last_step = (k_q == LAST_STEP);

    norm1_udiv_step #(
        .W      (din1_WIDTH)
    ) u_step (
        .r      (r_q),
        .d      (div_q),
        .bit_in (q_q[dout_WIDTH-1]),
        .r_out  (step_r),
        .q_bit  (step_bit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = ovf_n ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ap_idle  = is_idle;
        bus.ap_ready = accept;
        bus.ap_done  = (state_q == DONE);
        bus.dout     = dout_q;
        bus.rem      = rem_q;
        bus.ovf      = ovf_q;
    end

    // Result registers only move when a result lands, so they hold through CALC.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            div_q  <= '0;
            r_q    <= '0;
            q_q    <= '0;
            k_q    <= '0;
            dout_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            div_q <= bus.din1;
            if (ovf_n) begin
                dout_q <= Q_SAT;
                rem_q  <= '0;
                ovf_q  <= 1'b1;
            end else begin
                r_q <= bus.din0[din0_WIDTH-1:dout_WIDTH];
                q_q <= bus.din0[dout_WIDTH-1:0];
                k_q <= '0;
            end
        end else if (state_q == CALC) begin
            r_q <= step_r;
            q_q <= {q_q[dout_WIDTH-2:0], step_bit};
            k_q <= k_q + 1'b1;
            if (last_step) begin
                dout_q <= {q_q[dout_WIDTH-2:0], step_bit};
                rem_q  <= step_r;
                ovf_q  <= 1'b0;
            end
        end
    end

endmodule : norm1_udiv_36ns_18ns_18_seq
`default_nettype wire

// File: tb/tb_norm1_udiv_36ns_18ns_18_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_norm1_udiv_36ns_18ns_18_seq
// Brief   : Directed-vector and random self-checking bench for the norm1 divider
// Revision: 1.0
// ============================================================================
module tb_norm1_udiv_36ns_18ns_18_seq;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 ap_clk = ~ap_clk;

    norm1_udiv_36ns_18ns_18_seq_if bus ();

    norm1_udiv_36ns_18ns_18_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [35:0] a;
        logic [17:0] b;
        logic [17:0] q;
        logic [17:0] r;
        logic        o;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [35:0] a, input logic [17:0] b);
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        @(negedge ap_clk);
        chk("ready_on_accept", {35'b0, bus.ap_ready}, 36'd1);
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int idle_seen);
        lat       = 0;
        idle_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge ap_clk);
            if (bus.ap_done) begin
                lat = c;
                break;
            end
            if (bus.ap_idle) idle_seen++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          idle_seen;
        int          cnt;
        logic [63:0] rnd;
        logic [35:0] a;
        logic [17:0] b;
        logic [35:0] eq;
        logic [35:0] er;
        logic        eo;

        vecs[0]  = '{36'd1000,        18'd7,       18'd142,     18'd6,       1'b0, 19};
        vecs[1]  = '{36'hFFFFBFFFF,   18'h3FFFF,   18'h3FFFF,   18'h3FFFE,   1'b0, 19};
        vecs[2]  = '{36'h40000,       18'd1,       18'h3FFFF,   18'd0,       1'b1, 1};
        vecs[3]  = '{36'd5,           18'd0,       18'h3FFFF,   18'd0,       1'b1, 1};
        vecs[4]  = '{36'd100,         18'd10,      18'd10,      18'd0,       1'b0, 19};
        vecs[5]  = '{36'd99,          18'd10,      18'd9,       18'd9,       1'b0, 19};
        vecs[6]  = '{36'd0,           18'd5,       18'd0,       18'd0,       1'b0, 19};
        vecs[7]  = '{36'h3FFFF,       18'd1,       18'h3FFFF,   18'd0,       1'b0, 19};
        vecs[8]  = '{36'hFFFFFFFFF,   18'h3FFFF,   18'h3FFFF,   18'd0,       1'b1, 1};
        vecs[9]  = '{36'd123456789,   18'd1000,    18'd123456,  18'd789,     1'b0, 19};
        vecs[10] = '{36'd7,           18'd7,       18'd1,       18'd0,       1'b0, 19};
        vecs[11] = '{36'd6,           18'd7,       18'd0,       18'd6,       1'b0, 19};

        bus.ap_start = 1'b1;
        bus.din0     = '0;
        bus.din1     = '0;

        // Reset state, with a pending start that must not be reported ready
        #12;
        chk("rst_dout",  {18'b0, bus.dout}, 36'd0);
        chk("rst_rem",   {18'b0, bus.rem},  36'd0);
        chk("rst_ovf",   {35'b0, bus.ovf},     36'd0);
        chk("rst_idle",  {35'b0, bus.ap_idle}, 36'd1);
        chk("rst_done",  {35'b0, bus.ap_done}, 36'd0);
        chk("rst_ready", {35'b0, bus.ap_ready}, 36'd0);
        bus.ap_start = 1'b0;
        #10;
        ap_rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            if (bus.ap_done) cnt++;
        end
        chk("no_done_after_reset", cnt, 0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(lat, idle_seen);
            chk($sformatf("vec%0d_lat", i),  lat, vecs[i].lat);
            chk($sformatf("vec%0d_dout", i), {18'b0, bus.dout}, {18'b0, vecs[i].q});
            chk($sformatf("vec%0d_rem", i),  {18'b0, bus.rem},  {18'b0, vecs[i].r});
            chk($sformatf("vec%0d_ovf", i),  {35'b0, bus.ovf},  {35'b0, vecs[i].o});
            if (vecs[i].lat == 19) chk($sformatf("vec%0d_idle_calc", i), idle_seen, 0);
        end
        @(negedge ap_clk);
        chk("done_one_cycle", {35'b0, bus.ap_done}, 36'd0);

        // Asynchronous abort mid-CALC: outputs clear at once, no ap_done follows
        issue(36'd1000, 18'd7);
        repeat (5) @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("abort_dout", {18'b0, bus.dout}, 36'd0);
        chk("abort_rem",  {18'b0, bus.rem},  36'd0);
        chk("abort_ovf",  {35'b0, bus.ovf},     36'd0);
        chk("abort_idle", {35'b0, bus.ap_idle}, 36'd1);
        chk("abort_done", {35'b0, bus.ap_done}, 36'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge ap_clk);
            if (bus.ap_done) cnt++;
        end
        chk("no_done_after_abort", cnt, 0);

        // Back-to-back with ap_start held high and operands wiggling during CALC
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b1;
        bus.din0     = 36'd100;
        bus.din1     = 18'd10;
        @(negedge ap_clk);
        chk("b2b_ready0", {35'b0, bus.ap_ready}, 36'd1);
        cnt = 0;
        for (int c = 1; c <= 19; c++) begin
            @(posedge ap_clk);
            #1;
            if (c == 3) begin
                bus.din0 = 36'hABCDE1234;
                bus.din1 = 18'd3;
            end
            if (c == 12) begin
                bus.din0 = 36'd99;
                bus.din1 = 18'd10;
            end
            @(negedge ap_clk);
            if (c < 19) begin
                if (bus.ap_ready) cnt++;
            end else begin
                chk("b2b_done1",  {35'b0, bus.ap_done},  36'd1);
                chk("b2b_dout1",  {18'b0, bus.dout},     36'd10);
                chk("b2b_rem1",   {18'b0, bus.rem},      36'd0);
                chk("b2b_ready19", {35'b0, bus.ap_ready}, 36'd1);
            end
        end
        chk("b2b_ready_in_calc", cnt, 0);
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b0;
        wait_done(lat, idle_seen);
        chk("b2b_lat2",  lat, 19);
        chk("b2b_dout2", {18'b0, bus.dout}, 36'd9);
        chk("b2b_rem2",  {18'b0, bus.rem},  36'd9);

        // Random operands against a golden quotient/remainder model
        for (int n = 0; n < 300; n++) begin
            rnd = {$urandom(), $urandom()};
            a   = rnd[35:0];
            b   = 18'($urandom());
            if (n % 4 == 1) b = 18'($urandom_range(0, 15));
            if ((n % 2 == 0) && (b != 0)) a[35:18] = a[35:18] % b;
            if (a[35:18] >= b) begin
                eq = 36'h3FFFF;
                er = 36'd0;
                eo = 1'b1;
            end else begin
                eq = a / {18'b0, b};
                er = a % {18'b0, b};
                eo = 1'b0;
            end
            issue(a, b);
            wait_done(lat, idle_seen);
            chk("rnd_lat",  lat, eo ? 1 : 19);
            chk("rnd_dout", {18'b0, bus.dout}, eq);
            chk("rnd_rem",  {18'b0, bus.rem},  er);
            chk("rnd_ovf",  {35'b0, bus.ovf},  {35'b0, eo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_norm1_udiv_36ns_18ns_18_seq
`default_nettype wire
